segment_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_hex_decode.sv | 28 ++
 rtl/segment_scan_driver.sv | 150 +++++++++++++++
 tb/tb_segment_scan_driver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants and hex-to-segment helper for the seven-segment
//             scan driver.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Segment bit order on the pins, active-low:
   //   bit 7 = dp, 6 = g, 5 = f, 4 = e, 3 = d, 2 = c, 1 = b, 0 = a
   localparam int SEG_DP_BIT = 7;

   // All segments dark, including the decimal point.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low a..g pattern for one hex nibble (dp not included).
   function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'h0:    pattern = 7'h40;
         4'h1:    pattern = 7'h79;
         4'h2:    pattern = 7'h24;
         4'h3:    pattern = 7'h30;
         4'h4:    pattern = 7'h19;
         4'h5:    pattern = 7'h12;
         4'h6:    pattern = 7'h02;
         4'h7:    pattern = 7'h78;
         4'h8:    pattern = 7'h00;
         4'h9:    pattern = 7'h10;
         4'hA:    pattern = 7'h08;
         4'hB:    pattern = 7'h03;
         4'hC:    pattern = 7'h46;
         4'hD:    pattern = 7'h21;
         4'hE:    pattern = 7'h06;
         default: pattern = 7'h0E;
      endcase
      return pattern;
   endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Purpose  : Combinational nibble + decimal point + blank -> active-low
//             segment byte {dp,g,f,e,d,c,b,a}. The single decode point of
//             the scan driver.
//  Ports    : nibble  in  4   hex digit to show
//             dp      in  1   decimal point, active-high
//             blank   in  1   1 = darken a..g (dp still follows dp)
//             seg     out 8   active-low segment pattern
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   logic [6:0] w_digit;

   assign w_digit = blank ? SEG_BLANK[6:0] : seg7_hex(nibble);
   assign seg     = {~dp, w_digit};

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/segment_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : segment_scan_driver
//  Purpose  : Time-multiplexed driver for NUM_DIGITS common-anode
//             seven-segment digits with hex decode, per-digit decimal point,
//             leading-zero blanking and tear-free double-buffered updates.
//  Ports    : clk         in   1             system clock, rising edge
//             rst         in   1             asynchronous reset, active-high
//             enable      in   1             1 = display on, 0 = all dark
//             load        in   1             strobe: capture value_in/dp_in
//             value_in    in   4*NUM_DIGITS  packed nibbles, [3:0] = digit 0
//             dp_in       in   NUM_DIGITS    decimal points, active-high
//             hexOut      out  8             segments, active-low
//             anodeOut    out  NUM_DIGITS    digit selects, active-low
//             frame_done  out  1             pulse after scan wraps to 0
//  Revision : 1.0 - initial release
// ============================================================================
module segment_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   output logic [7:0]                hexOut,
   output logic [NUM_DIGITS-1:0]     anodeOut,
   output logic                      frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]          prescale;
   logic [IDX_W-1:0]          index;
   logic                      tick;
   logic                      wrap;

   logic [4*NUM_DIGITS-1:0]   pending_val;
   logic [NUM_DIGITS-1:0]     pending_dp;
   logic                      pending_valid;
   logic [4*NUM_DIGITS-1:0]   disp_val;
   logic [NUM_DIGITS-1:0]     disp_dp;

   logic [IDX_W-1:0]          highest_nz;
   logic [3:0]                cur_nibble;
   logic                      cur_dp;
   logic                      cur_blank;
   logic [7:0]                cur_seg;
   logic [NUM_DIGITS-1:0]     anode_next;

   assign tick = (prescale == CNT_MAX);
   // The last-digit tick is the frame boundary: scan wraps and buffers swap.
   assign wrap = tick && (index == IDX_MAX);

   // ---------------------------------------------------------------- scan
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale   <= '0;
         index      <= '0;
         frame_done <= 1'b0;
      end else begin
         prescale   <= tick ? '0 : prescale + CNT_W'(1);
         frame_done <= wrap;
         if (tick) begin
            index <= (index == IDX_MAX) ? '0 : index + IDX_W'(1);
         end
      end
   end

   // ---------------------------------------------------------- buffering
   // Loads land in the pending buffer; the display buffer only changes at
   // the frame boundary so a frame never mixes old and new digits. A load
   // in the boundary cycle itself bypasses pending and goes straight in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_val   <= '0;
         pending_dp    <= '0;
         pending_valid <= 1'b0;
         disp_val      <= '0;
         disp_dp       <= '0;
      end else if (wrap) begin
         pending_valid <= 1'b0;
         if (load) begin
            disp_val <= value_in;
            disp_dp  <= dp_in;
         end else if (pending_valid) begin
            disp_val <= pending_val;
            disp_dp  <= pending_dp;
         end
      end else if (load) begin
         pending_val   <= value_in;
         pending_dp    <= dp_in;
         pending_valid <= 1'b1;
      end
   end

   // ----------------------------------------------- leading-zero priority
   // Highest non-zero digit index; stays 0 for an all-zero value so digit 0
   // is never blanked.
   always_comb begin
      highest_nz = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (disp_val[4*i +: 4] != 4'h0) begin
            highest_nz = IDX_W'(i);
         end
      end
   end

   assign cur_nibble = disp_val[4*index +: 4];
   assign cur_dp     = disp_dp[index];
   assign cur_blank  = (BLANK_LEADING != 0) && (index > highest_nz);

   seg7_hex_decode u_decode (
      .nibble (cur_nibble),
      .dp     (cur_dp),
      .blank  (cur_blank),
      .seg    (cur_seg)
   );

   always_comb begin
      anode_next = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         anode_next[i] = (index != IDX_W'(i));
      end
   end

   // ------------------------------------------------------ output regs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hexOut   <= SEG_BLANK;
         anodeOut <= '1;
      end else if (!enable) begin
         hexOut   <= SEG_BLANK;
         anodeOut <= '1;
      end else begin
         hexOut   <= cur_seg;
         anodeOut <= anode_next;
      end
   end

endmodule : segment_scan_driver
`default_nettype wire

// File: tb/tb_segment_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segment_scan_driver
//  Purpose  : Self-checking bench for segment_scan_driver. Three instances
//             share stimulus: 4 digits with blanking, 4 digits without
//             blanking, and a single-digit build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segment_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;

   logic [7:0]  hex,    hex_nb,    hex1;
   logic [3:0]  anode,  anode_nb;
   logic [0:0]  anode1;
   logic        fd,     fd_nb,     fd1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] cur_val;
   logic [3:0]  cur_dp;

   typedef struct {
      logic [3:0] an;
      logic [7:0] hex;
      logic [7:0] hex_nb;
      logic [7:0] hex1;
   } exp_t;

   exp_t sb[$];

   logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   always #5 clk = ~clk;

   segment_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load),
      .value_in(value_in), .dp_in(dp_in),
      .hexOut(hex), .anodeOut(anode), .frame_done(fd));

   segment_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(0)) dut_nb (
      .clk(clk), .rst(rst), .enable(enable), .load(load),
      .value_in(value_in), .dp_in(dp_in),
      .hexOut(hex_nb), .anodeOut(anode_nb), .frame_done(fd_nb));

   segment_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .load(load),
      .value_in(value_in[3:0]), .dp_in(dp_in[0:0]),
      .hexOut(hex1), .anodeOut(anode1), .frame_done(fd1));

   // Reference for one digit of a 4-digit display.
   function automatic logic [7:0] model(input logic [15:0] v, input logic [3:0] dp,
                                        input int k, input bit bl);
      int hi;
      logic [3:0] n;
      logic [7:0] r;
      hi = 0;
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) hi = i;
      n = v[4*k +: 4];
      r = (bl && (k > hi)) ? 8'hFF : tbl[n];
      r[7] = ~dp[k];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      value_in = v;
      dp_in    = dp;
      load     = 1'b1;
      step();
      load     = 1'b0;
      cur_val  = v;
      cur_dp   = dp;
   endtask

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.an     = ~(4'b0001 << k);
         e.hex    = model(v, dp, k, 1'b1);
         e.hex_nb = model(v, dp, k, 1'b0);
         e.hex1   = model(v, dp, 0, 1'b1);
         sb.push_back(e);
      end
   endtask

   // Steps at least once, then until frame_done is seen (bounded).
   task automatic wait_wrap();
      int n = 0;
      do begin
         step();
         n++;
      end while (fd !== 1'b1 && n < 40);
      chk("wrap_seen", 32'(fd), 32'd1);
   endtask

   // Called on the first cycle digit 0 is on the pins.
   task automatic check_frame_now();
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
            return;
         end
         e = sb.pop_front();
         chk($sformatf("anode_d%0d", k),    32'(anode),    32'(e.an));
         chk($sformatf("hex_d%0d", k),      32'(hex),      32'(e.hex));
         chk($sformatf("anode_nb_d%0d", k), 32'(anode_nb), 32'(e.an));
         chk($sformatf("hex_nb_d%0d", k),   32'(hex_nb),   32'(e.hex_nb));
         chk($sformatf("anode1_d%0d", k),   32'(anode1),   32'd0);
         chk($sformatf("hex1_d%0d", k),     32'(hex1),     32'(e.hex1));
         if (k < 3) repeat (4) step();
      end
   endtask

   task automatic drain_frame();
      wait_wrap();
      step();
      check_frame_now();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] old_val;
      logic [3:0]  old_dp;
      int t0;
      int n;

      rst = 1'b1; enable = 1'b1; load = 1'b0; value_in = '0; dp_in = '0;
      cur_val = '0; cur_dp = '0;

      // ---- reset state and first tick timing
      repeat (2) step();
      chk("rst_hex",   32'(hex),    32'hFF);
      chk("rst_anode", 32'(anode),  32'hF);
      chk("rst_fd",    32'(fd),     32'd0);
      chk("rst_hex1",  32'(hex1),   32'hFF);
      chk("rst_anode1",32'(anode1), 32'd1);
      rst = 1'b0;
      step();
      chk("post_rst_anode", 32'(anode), 32'hE);
      chk("post_rst_hex",   32'(hex),   32'hC0);
      repeat (3) step();
      chk("pre_tick_anode", 32'(anode), 32'hE);
      step();
      chk("first_change_anode", 32'(anode), 32'hD);

      // ---- basic scan, two frames
      do_load(16'h12AF, 4'b0100);
      push_frame(16'h12AF, 4'b0100);
      push_frame(16'h12AF, 4'b0100);
      drain_frame();
      drain_frame();

      // frame_done width and period
      wait_wrap();
      t0 = cyc;
      step();
      chk("fd_width", 32'(fd), 32'd0);
      wait_wrap();
      chk("fd_period", 32'(cyc - t0), 32'd16);

      // single-digit build: frame_done every REFRESH_DIV cycles
      n = 0;
      while (fd1 !== 1'b1 && n < 20) begin step(); n++; end
      t0 = cyc;
      n = 0;
      do begin step(); n++; end while (fd1 !== 1'b1 && n < 20);
      chk("fd1_period", 32'(cyc - t0), 32'd4);
      chk("anode1_fixed", 32'(anode1), 32'd0);

      // ---- tear-free update
      old_val = cur_val;
      old_dp  = cur_dp;
      wait_wrap();
      step();
      chk("tear_d0", 32'(hex), 32'(model(old_val, old_dp, 0, 1'b1)));
      do_load(16'h1234, 4'b0000);
      repeat (3) step();
      chk("tear_an1", 32'(anode), 32'hD);
      chk("tear_d1",  32'(hex),   32'(model(old_val, old_dp, 1, 1'b1)));
      do_load(16'h5678, 4'b0000);
      repeat (3) step();
      chk("tear_an2", 32'(anode), 32'hB);
      chk("tear_d2",  32'(hex),   32'(model(old_val, old_dp, 2, 1'b1)));
      repeat (4) step();
      chk("tear_an3", 32'(anode), 32'h7);
      chk("tear_d3",  32'(hex),   32'(model(old_val, old_dp, 3, 1'b1)));
      push_frame(16'h5678, 4'b0000);
      drain_frame();

      // ---- leading-zero blanking
      do_load(16'h0070, 4'b0000);
      push_frame(16'h0070, 4'b0000);
      drain_frame();
      do_load(16'h0000, 4'b0000);
      push_frame(16'h0000, 4'b0000);
      drain_frame();

      // ---- enable
      do_load(16'h8888, 4'b1111);
      push_frame(16'h8888, 4'b1111);
      drain_frame();
      wait_wrap();
      step();
      chk("en_d0", 32'(hex), 32'(model(16'h8888, 4'b1111, 0, 1'b1)));
      enable = 1'b0;
      step();
      chk("dis_hex",    32'(hex),      32'hFF);
      chk("dis_anode",  32'(anode),    32'hF);
      chk("dis_anodenb",32'(anode_nb), 32'hF);
      chk("dis_hex1",   32'(hex1),     32'hFF);
      chk("dis_anode1", 32'(anode1),   32'd1);
      repeat (4) step();
      chk("dis_hex_mid",   32'(hex),   32'hFF);
      chk("dis_anode_mid", 32'(anode), 32'hF);
      repeat (5) step();
      enable = 1'b1;
      step();
      chk("reen_anode", 32'(anode), 32'hB);
      chk("reen_hex",   32'(hex),   32'(model(16'h8888, 4'b1111, 2, 1'b1)));
      step();
      chk("reen_anode3", 32'(anode), 32'h7);
      t0 = cyc;
      wait_wrap();
      chk("reen_fd_timing", 32'(cyc - t0), 32'd3);

      // ---- load coinciding with the wrapping tick (pending load superseded)
      do_load(16'h1111, 4'b0000);
      repeat (14) step();
      value_in = 16'h9ABC;
      dp_in    = 4'b0001;
      load     = 1'b1;
      step();
      load     = 1'b0;
      cur_val  = 16'h9ABC;
      cur_dp   = 4'b0001;
      chk("coinc_wrap", 32'(fd), 32'd1);
      step();
      push_frame(16'h9ABC, 4'b0001);
      check_frame_now();

      // ---- reset mid-frame drops pending data
      do_load(16'h4321, 4'b0000);
      rst = 1'b1;
      #1;
      chk("midrst_hex",   32'(hex),   32'hFF);
      chk("midrst_anode", 32'(anode), 32'hF);
      chk("midrst_fd",    32'(fd),    32'd0);
      chk("midrst_fd1",   32'(fd1),   32'd0);
      step();
      rst = 1'b0;
      cur_val = '0;
      cur_dp  = '0;
      push_frame(16'h0000, 4'b0000);
      drain_frame();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_segment_scan_driver
`default_nettype wire
